// File: rtl/tpsram_pkg.sv
// Shared constants and helpers for the tpsram-backed FIFO controller.
package tpsram_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 32;

  // Advance a pointer by one, wrapping DEPTH-1 -> 0 by explicit compare so
  // that depths which are not a power of two still cycle correctly.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tpsram_fifo_ctrl_if.sv
// Valid/ready stream pair for the FIFO controller: producer side (in_*)
// and consumer side (out_*). The controller takes the slave view.
interface tpsram_fifo_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/tpsram.sv
// Two-port SRAM macro model: one write port, one read port with a
// registered (1-cycle) read.
module tpsram #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 re,
  input  logic [DEPTH_LOG-1:0] ra,
  output logic [WIDTH-1:0]     rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset; a real macro cannot clear itself, and the
  // controller never reads a word it has not written first.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read port: data appears on rd the cycle after re.
  always_ff @(posedge clk) begin
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/tpsram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one tpsram. A two-entry
// register stage in front of the output absorbs the SRAM read latency so the
// stream runs at one word per cycle.
module tpsram_fifo_ctrl
  import tpsram_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  tpsram_fifo_ctrl_if.slave    bus,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int                 CW      = DEPTH_LOG + 1;
  localparam logic [DEPTH_LOG:0] DEPTH_W = CW'(DEPTH);

  logic [DEPTH_LOG-1:0] wptr;
  logic [DEPTH_LOG-1:0] rptr;
  logic [DEPTH_LOG:0]   mem_cnt;   // words written to SRAM, not yet read
  logic                 inflight;  // read issued last cycle, rd valid now
  logic [1:0]           ost_cnt;   // output-stage occupancy, 0..2
  logic [WIDTH-1:0]     ost_head;
  logic [WIDTH-1:0]     ost_tail;

  logic                 push;
  logic                 pop;
  logic                 we;
  logic                 re;
  logic [WIDTH-1:0]     rd;
  logic [1:0]           kept;      // stage entries surviving this cycle's pop
  logic [1:0]           ost_next;
  logic [WIDTH-1:0]     head_n;
  logic [WIDTH-1:0]     tail_n;

  // Occupancy and flags come only from registered state.
  assign count = mem_cnt + CW'(inflight) + CW'(ost_cnt);
  assign full  = (count == DEPTH_W);
  assign empty = (count == '0);

  assign bus.in_ready  = rst_n & (count < DEPTH_W);
  assign bus.out_valid = (ost_cnt != 2'd0);
  assign bus.out_data  = ost_head;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // A flush must leave SRAM contents alone, so a push that clr discards
  // does not reach the write port either.
  assign we = push & ~clr;

  assign kept     = ost_cnt - 2'(pop);
  assign ost_next = kept + 2'(inflight);

  // Only issue a read when the returning word is guaranteed a stage slot.
  assign re = (mem_cnt != '0) & (ost_next < 2'd2) & ~clr;

  tpsram #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_tpsram (
    .clk (clk),
    .we  (we),
    .wa  (wptr),
    .wd  (bus.in_data),
    .re  (re),
    .ra  (rptr),
    .rd  (rd)
  );

  // Output stage shift: pop moves tail to head, then the returning SRAM word
  // lands in the first free slot.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    head_n = ost_head;
    tail_n = ost_tail;
    if (pop) head_n = ost_tail;
    if (inflight) begin
      if (kept == 2'd0) head_n = rd;
      else              tail_n = rd;
    end
  end

  // Pointer, counter and output-stage registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and ordering inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ost_cnt  <= 2'd0;
      ost_head <= '0;
      ost_tail <= '0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ost_cnt  <= 2'd0;
    end else begin
      if (push) wptr <= DEPTH_LOG'(next_ptr(int'(wptr), DEPTH));
      if (re)   rptr <= DEPTH_LOG'(next_ptr(int'(rptr), DEPTH));
      mem_cnt  <= mem_cnt + CW'(push) - CW'(re);
      inflight <= re;
      ost_cnt  <= ost_next;
      ost_head <= head_n;
      ost_tail <= tail_n;
    end
  end

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Self-checking bench for tpsram_fifo_ctrl: a word queue is the reference
// model; each scenario task drives stimulus and checks its own expectations.
module tb_tpsram_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;

  tpsram_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  tpsram_fifo_ctrl #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int               n_cmp      = 0;
  int               n_mis      = 0;
  int               n_pops     = 0;
  int               n_pushes   = 0;
  logic [WIDTH-1:0] model_q[$];
  logic             hold_valid = 1'b0;
  logic [WIDTH-1:0] hold_data  = '0;
  logic             smp_valid  = 1'b0;

  // One clock cycle: drive inputs at the falling edge, sample just after,
  // check invariants against the model and predict this edge's handshakes.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic c);
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = c;
    #1;
    n_cmp++;
    if (int'(count) != model_q.size()) begin
      n_mis++;
      $display("FAIL count: got %0d expected %0d", count, model_q.size());
    end
    n_cmp++;
    if (full !== (model_q.size() == DEPTH)) begin
      n_mis++;
      $display("FAIL full: got %b expected %b", full, model_q.size() == DEPTH);
    end
    n_cmp++;
    if (empty !== (model_q.size() == 0)) begin
      n_mis++;
      $display("FAIL empty: got %b expected %b", empty, model_q.size() == 0);
    end
    n_cmp++;
    if (bus.in_ready !== (model_q.size() < DEPTH)) begin
      n_mis++;
      $display("FAIL in_ready: got %b expected %b", bus.in_ready, model_q.size() < DEPTH);
    end
    if (hold_valid) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== hold_data) begin
        n_mis++;
        $display("FAIL hold_stable: got valid=%b data=%h expected valid=1 data=%h",
                 bus.out_valid, bus.out_data, hold_data);
      end
    end
    smp_valid = bus.out_valid;
    if (c) begin
      model_q.delete();
      hold_valid = 1'b0;
    end else begin
      hold_valid = bus.out_valid & ~ordy;
      hold_data  = bus.out_data;
      if (bus.out_valid && ordy) begin
        n_cmp++;
        if (model_q.size() == 0) begin
          n_mis++;
          $display("FAIL pop_data: got %h expected no word (model empty)", bus.out_data);
        end else begin
          exp = model_q.pop_front();
          if (bus.out_data !== exp) begin
            n_mis++;
            $display("FAIL pop_data: got %h expected %h", bus.out_data, exp);
          end
        end
        n_pops++;
      end
      if (iv && bus.in_ready) begin
        model_q.push_back(d);
        n_pushes++;
      end
    end
  endtask

  // Pop until the model is empty, within a cycle budget.
  task automatic drain(input int budget);
    int n = 0;
    while (model_q.size() != 0 && n < budget) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    n_cmp++;
    if (model_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain_timeout: got %0d words left expected 0", model_q.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_flags: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_outputs: got valid=%b data=%h in_ready=%b expected 0/0/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'(32'h10 + i), 1'b0, 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    n_cmp++;
    if (full !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL fill_full: got full=%b in_ready=%b expected 1/0", full, bus.in_ready);
    end
    drain(30);
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL drain_empty: got empty=%b out_valid=%b expected 1/0", empty, bus.out_valid);
    end
  endtask

  task automatic test_latency();
    logic [2:0] seen;
    drive(1'b1, 32'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      seen[i] = bus.out_valid;
    end
    n_cmp++;
    if (seen !== 3'b100) begin
      n_mis++;
      $display("FAIL latency_valid: got k+1..k+3 valid=%b expected 100", seen);
    end
    n_cmp++;
    if (bus.out_data !== 32'hA5) begin
      n_mis++;
      $display("FAIL latency_data: got %h expected a5", bus.out_data);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 4'd0) begin
      n_mis++;
      $display("FAIL latency_count: got %0d expected 0", count);
    end
  endtask

  task automatic test_streaming();
    int start    = n_pops;
    int bubbles  = 0;
    int max_cnt  = 0;
    logic active = 1'b0;
    for (int i = 0; i < 60 && (n_pops - start) < 20; i++) begin
      drive(i < 20, 32'(32'h100 + i), 1'b1, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (smp_valid) active = 1'b1;
      else if (active) bubbles++;
    end
    n_cmp++;
    if (n_pops - start != 20) begin
      n_mis++;
      $display("FAIL stream_pops: got %0d expected 20", n_pops - start);
    end
    n_cmp++;
    if (bubbles != 0) begin
      n_mis++;
      $display("FAIL stream_bubbles: got %0d expected 0", bubbles);
    end
    n_cmp++;
    if (max_cnt > 3) begin
      n_mis++;
      $display("FAIL stream_count_max: got %0d expected <= 3", max_cnt);
    end
  endtask

  task automatic test_backpressure();
    int push0 = n_pushes;
    int pop0  = n_pops;
    for (int i = 0; i < 120; i++)
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    drain(40);
    n_cmp++;
    if ((n_pushes - push0) != (n_pops - pop0)) begin
      n_mis++;
      $display("FAIL bp_balance: got %0d pops expected %0d", n_pops - pop0, n_pushes - push0);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h66, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL flush_state: got count=%0d out_valid=%b expected 0/0", count, bus.out_valid);
    end
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77) begin
      n_mis++;
      $display("FAIL flush_next: got valid=%b data=%h expected 1/77", bus.out_valid, bus.out_data);
    end
    drain(10);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(32'hC0 + i), 1'b0, 1'b0);
    @(negedge clk);
    rst_n         = 1'b0;
    clr           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL midrst_ready: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (count !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL midrst_state: got count=%0d valid=%b data=%h in_ready=%b expected 0/0/0/0",
               count, bus.out_valid, bus.out_data, bus.in_ready);
    end
    model_q.delete();
    hold_valid   = 1'b0;
    rst_n        = 1'b1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    drain(10);
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (empty !== 1'b1) begin
      n_mis++;
      $display("FAIL midrst_after: got empty=%b expected 1", empty);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tpsram_fifo_ctrl.md
Name: tpsram_fifo_ctrl

Overview:
- Synchronous FIFO controller built around one tpsram instance (DEPTH x WIDTH, one write port, one read port).
- Generates write/read addresses and enables, and tracks occupancy.
- A 2-entry output stage hides the SRAM's 1-cycle registered read latency, giving first-word-fall-through valid/ready streaming at 1 word/cycle.
- Used wherever a block needs elastic buffering backed by the two-port SRAM macro.

Parameters:
- DEPTH, 8, number of SRAM words; must be ≥2.
- WIDTH, 32, data width in bits.
- DEPTH_LOG, $clog2(DEPTH), SRAM address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- clr  in  1  synchronous flush; empties FIFO, discards in-flight read.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  write data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts word.
- out_data  out  WIDTH  head-of-FIFO data.
- count  out  DEPTH_LOG+1  total words held, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready, both evaluated at the rising edge. Once asserted, out_valid and out_data hold stable until pop. in_ready does not depend combinationally on out_ready or in_valid.
- State:
  - wptr and rptr (DEPTH_LOG bits).
  - mem_cnt (0..DEPTH): written words not yet read.
  - inflight (1 bit): read issued last cycle.
  - ost_cnt (0..2): output-stage entries.
  - count = mem_cnt + inflight + ost_cnt.
- SRAM write: we = push, wa = wptr, wd = in_data.
  - wptr increments on push and wraps DEPTH-1 → 0 by explicit compare, so non-power-of-2 DEPTH works.
- SRAM read: re = (mem_cnt > 0) & ((ost_cnt + inflight − pop) < 2) & ~clr; ra = rptr.
  - rptr increments on re with the same wrap rule.
  - mem_cnt counts only words committed at a previous edge, so a read never targets the address being written in the same cycle.
- Read return: when inflight = 1, the tpsram rd output is captured into the output stage at the next edge.
- Output stage: 2-entry register FIFO.
  - out_data = head entry; out_valid = (ost_cnt ≠ 0).
  - A simultaneous capture and pop shifts the stage correctly, with no loss and no duplication.
- Latency: push accepted at edge k into an empty FIFO:
  - re is high in cycle k..k+1;
  - rd is valid after edge k+1;
  - out_valid is high after edge k+2 (2-cycle fall-through).
- Throughput: sustained 1 push + 1 pop per cycle with no bubbles once the output stage is primed.
- Full/empty:
  - in_ready = (count < DEPTH); a push with in_ready = 0 is ignored.
  - Pushing while full and popping in the same cycle is not accepted that cycle; in_ready rises on the following cycle.
- Flags: full and empty are derived from registered count (no combinational input paths).
- clr (when rst_n = 1): at the edge, wptr/rptr/mem_cnt/inflight/ost_cnt go to 0.
  - A push or pop in the same cycle is discarded.
  - The pending read's rd is ignored.
  - SRAM contents are untouched.
- Reset (rst_n = 0 at an edge):
  - count = 0, empty = 1, full = 0, out_valid = 0, out_data = 0;
  - all pointers and counters = 0;
  - in_ready forced 0 while rst_n = 0, then 1 from the first cycle after release.
  - Reset overrides clr.
- Simultaneous push + pop at the same count: count is unchanged.
- Address wrap: wptr and rptr wrap independently; ordering is preserved across the wrap.

Decomposition:
- Shared package tpsram_pkg holds:
  - default DEPTH/WIDTH constants;
  - a function computing the next pointer with wrap at DEPTH-1.
- Natural sub-module: tpsram (existing macro model), instantiated as u_tpsram with the controller's wa/ra/we/re/wd/rd.
- The output stage stays inline.

Test Plan:
- Fill/drain:
  - Stimulus: out_ready = 0, push 0x10..0x17.
  - Expect: full = 1 and in_ready = 0 after the 8th push; a 9th push (0x99) is rejected.
  - Then out_ready = 1: pops 0x10..0x17 in order, then empty = 1, out_valid = 0.
- Latency:
  - Stimulus: single push 0xA5 into an empty FIFO at edge k, out_ready = 1.
  - Expect: out_valid = 1, out_data = 0xA5 after edge k+2; count returns to 0 after the pop.
- Streaming:
  - Stimulus: 20 back-to-back pushes 0x100..0x113 with out_ready = 1.
  - Expect: 20 pops in order, each pointer wraps twice, no bubble after the first output, count ≤ 3.
- Backpressure:
  - Stimulus: streaming with out_ready toggling 1,0,0,1 pseudo-randomly.
  - Expect: no loss or duplication; out_data stable while out_valid & ~out_ready.
- Flush:
  - Stimulus: push 0x1..0x5, pop 2, assert clr in the cycle a read is in flight.
  - Expect: count = 0, out_valid = 0 next cycle; a subsequent push 0x77 is the next pop.
- Reset mid-operation:
  - Stimulus: with 4 words held, drive rst_n = 0 for 1 edge.
  - Expect: count = 0, out_valid = 0, out_data = 0, in_ready = 0 during reset; after release, push/pop of 0x55 works normally.
